// File: rtl/core_pkg.sv
// Shared encodings for the five-stage pipeline: result-source select, access size
// and the memory-stage FSM state type.
package core_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mstate_t;

  function automatic logic is_half(logic [2:0] size);
    return (size == SZ_H) || (size == SZ_HU);
  endfunction

endpackage

// File: rtl/stage_m_if.sv
// Request/acknowledge data-memory bus between the memory stage and data memory.
interface stage_m_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lane.sv
// Byte-lane steering for data memory: store byte enables and replication, load lane
// select with sign/zero extension. Purely combinational.
module mem_lane
  import core_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_B, SZ_BU: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (size_i == SZ_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      SZ_H, SZ_HU: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (size_i == SZ_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_m.sv
// Memory stage: E/M pipeline register, data-memory request/ack FSM with timeout,
// misalignment detection and the registered load result for writeback.
module stage_m
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  SizeE,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ReadDataW,
  output logic        StallM,
  output logic        ErrM,
  stage_m_if.master   dmem
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [31:0] alu_q, wdata_q, pc4_q, rdata_w_q;
  logic [4:0]  rd_q;
  logic        pcsrc_q, regwrite_q, memwrite_q;
  logic [1:0]  ressrc_q;
  logic [2:0]  size_q;

  mstate_t        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        mem_acc, misalign, issue, timeout, req, done, stall, err;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // E/M register: frozen while the memory access is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q      <= '0;
      wdata_q    <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      ressrc_q   <= '0;
      size_q     <= '0;
    end else if (!stall) begin
      alu_q      <= ALUResultE;
      wdata_q    <= WriteDataE;
      pc4_q      <= PCPlus4E;
      rd_q       <= RdE;
      pcsrc_q    <= PCSrcE;
      regwrite_q <= RegWriteE;
      memwrite_q <= MemWriteE;
      ressrc_q   <= ResultSrcE;
      size_q     <= SizeE;
    end
  end

  mem_lane u_lane (
    .size_i  (size_q),
    .addr_i  (alu_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (dmem.rdata),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign mem_acc  = memwrite_q || (ressrc_q == RES_MEM);
  assign misalign = mem_acc && !arm &&
                    ((is_half(size_q) && alu_q[0]) || ((size_q == SZ_W) && (alu_q[1:0] != 2'b00)));
  assign timeout  = (TIMEOUT_CYC != 0) && (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter counts request cycles, so the issuing IDLE cycle enters WAIT as 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (issue && !dmem.ack) begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (timeout || dmem.ack) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue = (state_q == StIdle) && mem_acc && !misalign;
    req   = issue || ((state_q == StWait) && !timeout);
    done  = req && dmem.ack;
    stall = req && !dmem.ack;
    err   = ((state_q == StIdle) && misalign) || timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_w_q <= '0;
    end else if (done && (ressrc_q == RES_MEM) && !memwrite_q) begin
      rdata_w_q <= lane_rdata;
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = req && memwrite_q;
  assign dmem.addr  = {alu_q[31:2], 2'b00};
  assign dmem.be    = req ? lane_be : 4'b0000;
  assign dmem.wdata = lane_wdata;

  assign ALUResultM = alu_q;
  assign PCPlus4M   = pc4_q;
  assign RdM        = rd_q;
  assign ResultSrcM = ressrc_q;
  assign PCSrcM     = pcsrc_q && !stall;
  assign RegWriteM  = regwrite_q && !stall && !err;
  assign ReadDataW  = rdata_w_q;
  assign StallM     = stall;
  assign ErrM       = err;

endmodule
